// File: rtl/regfile_write_bank.sv
// Write side of the 32 x 32-bit register file.
// A write-back request is captured into a one-entry staging register and
// committed to the array on the following edge through a one-hot decode.
// Register 0 is hard-wired to zero, so writes to it are dropped at capture.
module regfile_write_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ctrl_writeEnable,
  input  logic [4:0]               ctrl_writeReg,
  input  logic [WIDTH-1:0]         data_writeReg,
  output logic [DEPTH*WIDTH-1:0]   regs_flat,
  output logic                     pend_valid,
  output logic [4:0]               pend_reg,
  output logic [WIDTH-1:0]         pend_data,
  output logic                     commit_ack
);

  // Staging register contents
  logic             pendValid;
  logic [4:0]       pendReg;
  logic [WIDTH-1:0] pendData;
  logic             commitAck;

  // Storage for registers 1..DEPTH-1; register 0 has no storage at all
  logic [WIDTH-1:0] regArray [1:DEPTH-1];

  // One-hot write enables for registers 1..DEPTH-1
  logic [DEPTH-1:1] writeSel;

  // A request is worth staging only if it targets a real register
  logic captureHit;

  assign captureHit = ctrl_writeEnable && (ctrl_writeReg != 5'd0);

  // Capture stage: load the staging register, or clear it so the pend_*
  // outputs read as zero whenever nothing is waiting to commit
  always_ff @(posedge clock) begin
    if (reset) begin
      pendValid <= 1'b0;
      pendReg   <= 5'd0;
      pendData  <= '0;
    end else if (captureHit) begin
      pendValid <= 1'b1;
      pendReg   <= ctrl_writeReg;
      pendData  <= data_writeReg;
    end else begin
      pendValid <= 1'b0;
      pendReg   <= 5'd0;
      pendData  <= '0;
    end
  end

  // 5-to-32 one-hot decode of the staged destination
  always_comb begin
    writeSel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      writeSel[i] = pendValid && (pendReg == 5'(i));
    end
  end

  // Commit stage: the selected register takes the staged data; reset
  // clears the array and drops anything still staged
  always_ff @(posedge clock) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        regArray[i] <= '0;
      end else if (writeSel[i]) begin
        regArray[i] <= pendData;
      end
    end
  end

  // Acknowledge pulse for the cycle after a staged write lands
  always_ff @(posedge clock) begin
    if (reset) begin
      commitAck <= 1'b0;
    end else begin
      commitAck <= pendValid;
    end
  end

  // Flatten the array for the read-port muxes; word 0 is constant zero
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gen_flat
      if (g == 0) begin : gen_zero
        assign regs_flat[WIDTH-1:0] = '0;
      end else begin : gen_word
        assign regs_flat[g*WIDTH +: WIDTH] = regArray[g];
      end
    end
  endgenerate

  assign pend_valid = pendValid;
  assign pend_reg   = pendReg;
  assign pend_data  = pendData;
  assign commit_ack = commitAck;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank with a commit scoreboard and a
// reference copy of the register array.
module tb_regfile_write_bank;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_writeEnable = 1'b0;
  logic [4:0]    ctrl_writeReg = 5'd0;
  logic [31:0]   data_writeReg = 32'd0;
  logic [1023:0] regs_flat;
  logic          pend_valid;
  logic [4:0]    pend_reg;
  logic [31:0]   pend_data;
  logic          commit_ack;

  regfile_write_bank #(.WIDTH(32), .DEPTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .regs_flat        (regs_flat),
    .pend_valid       (pend_valid),
    .pend_reg         (pend_reg),
    .pend_data        (pend_data),
    .commit_ack       (commit_ack)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          due;
  } commit_t;

  commit_t     sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;
  int          cycleNo = 0;

  function automatic logic [1023:0] modelFlat();
    logic [1023:0] f;
    f = '0;
    for (int i = 0; i < 32; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cycleNo, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then check everything
  // just after the following rising edge against the model
  task automatic applyStimulus(input logic rst, input logic en, input logic [4:0] r, input logic [31:0] d);
    logic [31:0]   prevModel [32];
    logic [1023:0] prevObs;
    logic          expAck;
    logic          expPend;
    logic [4:0]    expReg;
    logic [31:0]   expData;
    int            expChanged;
    int            obsChanged;
    commit_t       c;

    @(negedge clock);
    reset            = rst;
    ctrl_writeEnable = en;
    ctrl_writeReg    = r;
    data_writeReg    = d;
    prevObs          = regs_flat;
    prevModel        = model;

    @(posedge clock);
    cycleNo++;
    #1;

    expAck  = 1'b0;
    expPend = 1'b0;
    expReg  = 5'd0;
    expData = 32'd0;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cycleNo) begin
        expAck = 1'b1;
        c = sb.pop_front();
        model[c.r] = c.d;
      end
      if (en && r != 5'd0) begin
        sb.push_back('{r: r, d: d, due: cycleNo + 1});
        expPend = 1'b1;
        expReg  = r;
        expData = d;
      end
    end

    expChanged = 0;
    obsChanged = 0;
    for (int i = 0; i < 32; i++) begin
      if (model[i] != prevModel[i]) expChanged++;
      if (regs_flat[i*32 +: 32] !== prevObs[i*32 +: 32]) obsChanged++;
    end

    checkOutput("commit_ack", 1024'(commit_ack), 1024'(expAck));
    checkOutput("pend_valid", 1024'(pend_valid), 1024'(expPend));
    checkOutput("pend_reg",   1024'(pend_reg),   1024'(expReg));
    checkOutput("pend_data",  1024'(pend_data),  1024'(expData));
    checkOutput("regs_flat",  regs_flat,         modelFlat());
    if (!rst) checkOutput("words_changed", 1024'(obsChanged), 1024'(expChanged));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Reset then idle
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'd3, 32'h0BAD0BAD);

    // Single write to r5
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("r5_word", 1024'(regs_flat[191:160]), 1024'(32'hDEADBEEF));
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);

    // Write to r0 is dropped
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("r0_word", 1024'(regs_flat[31:0]), 1024'(32'h0));

    // Back-to-back, same destination twice
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h11);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h22);
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h33);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("r1_final", 1024'(regs_flat[63:32]), 1024'(32'h33));
    checkOutput("r2_final", 1024'(regs_flat[95:64]), 1024'(32'h22));

    // Reset right after a capture discards the staged write
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1234);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("r7_after_reset", 1024'(regs_flat[255:224]), 1024'(32'h0));

    // Sweep every writable index
    for (int i = 1; i < 32; i++) applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 32; i++) checkOutput("sweep_word", 1024'(regs_flat[i*32 +: 32]), 1024'(32'(i) * 32'h01010101));

    checkOutput("scoreboard_drained", 1024'(sb.size()), 1024'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the processor's 32 x 32-bit register file.
- Accepts one write-back request per cycle and holds it in a one-entry staging register.
- Decodes the 5-bit destination into a one-hot enable and commits the data to the selected register on the following cycle.
- All 32 register contents are exported as a flat bus; the read-port 32:1 word muxes select from that bus.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; fixed at 32 because the address is 5 bits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_writeEnable  input  1  write request valid this cycle.
- ctrl_writeReg  input  5  destination register index.
- data_writeReg  input  32  write data.
- regs_flat  output  1024  committed register contents; register i occupies bits [32*i+31 : 32*i].
- pend_valid  output  1  staging register holds an uncommitted write.
- pend_reg  output  5  destination of the staged write; 0 when pend_valid=0.
- pend_data  output  32  data of the staged write; 0 when pend_valid=0.
- commit_ack  output  1  one-cycle pulse in the cycle a staged write lands in the array.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All 32 registers clear to 0.
  - pend_valid, pend_reg, pend_data and commit_ack clear to 0.
  - Reset wins over every simultaneous request.
  - A write staged when reset asserts is discarded and never commits.
- Capture, at edge N:
  - Staging loads when ctrl_writeEnable=1 and ctrl_writeReg!=0: pend_valid<=1, pend_reg<=ctrl_writeReg, pend_data<=data_writeReg.
  - Otherwise pend_valid<=0 and pend_reg/pend_data<=0.
- Commit, at edge N+1 if pend_valid=1:
  - Register[pend_reg]<=pend_data through a 5-to-32 one-hot decode; exactly one enable is high.
  - commit_ack=1 during the cycle after that edge, and 0 otherwise.
- Latency: request at edge N is visible on regs_flat after edge N+1.
- Throughput: one write per cycle. Capture and commit overlap, so back-to-back requests each commit one cycle after capture with no stall or loss.
- Register 0:
  - Always reads 0.
  - A write to index 0 is dropped at capture: no pend_valid, no commit_ack.
- Same destination on consecutive cycles: each value commits in order, and the last request wins.
- regs_flat is driven only by the array. The staged write is not forwarded into it; read-side bypass uses the pend_* outputs.
- ctrl_writeEnable=0 leaves the array unchanged; ctrl_writeReg and data_writeReg are don't-care.
- No X propagation: every output is defined from the first post-reset cycle.

Test Plan:
- Reset, then idle 3 cycles:
  - regs_flat is all 0.
  - pend_valid=0, commit_ack=0.
- Single write, reg 5 <= 0xDEADBEEF at edge 1:
  - pend_valid=1, pend_reg=5 after edge 1.
  - regs_flat[191:160]=0xDEADBEEF and commit_ack=1 after edge 2.
  - All other words remain 0.
- Write reg 0 <= 0xFFFFFFFF:
  - pend_valid stays 0, commit_ack never pulses.
  - regs_flat[31:0] remains 0.
- Back-to-back writes on successive edges, r1=0x11, r2=0x22, r1=0x33:
  - Commits land in order.
  - Final r1=0x33, r2=0x22; commit_ack high 3 consecutive cycles.
- Reset mid-operation, write r7=0x1234 then assert reset on the next edge:
  - r7 stays 0, pend_valid=0.
  - No commit_ack after reset.
- Sweep all indices 1..31 writing value = index * 0x01010101:
  - Each word in regs_flat matches.
  - Exactly one register changes per commit (one-hot check).
